// File: rtl/nvdla_csb_initiator_if.sv
// Host command/completion and CSB request/response bundle for the CSB initiator.
// master = the initiator itself; slave = the host plus the glb target, as seen from the bench.
interface nvdla_csb_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [21:0] cmd_addr;
  logic [31:0] cmd_wdat;
  logic        cmd_write;
  logic        cmd_nposted;
  logic        csb2glb_req_pvld;
  logic        csb2glb_req_prdy;
  logic [62:0] csb2glb_req_pd;
  logic        glb2csb_resp_valid;
  logic [33:0] glb2csb_resp_pd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdat;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        proto_err;

  modport master (
    input  cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_nposted,
    input  csb2glb_req_prdy, glb2csb_resp_valid, glb2csb_resp_pd, rsp_ready,
    output cmd_ready, csb2glb_req_pvld, csb2glb_req_pd,
    output rsp_valid, rsp_rdat, rsp_error, rsp_timeout, proto_err
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_wdat, cmd_write, cmd_nposted,
    output csb2glb_req_prdy, glb2csb_resp_valid, glb2csb_resp_pd, rsp_ready,
    input  cmd_ready, csb2glb_req_pvld, csb2glb_req_pd,
    input  rsp_valid, rsp_rdat, rsp_error, rsp_timeout, proto_err
  );
endinterface

// File: rtl/nvdla_csb_initiator.sv
// Single-outstanding CSB master: host command -> csb2glb_req packet, glb2csb_resp -> host completion,
// with response timeout and sticky protocol-error detection.
module nvdla_csb_initiator #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rst,
  nvdla_csb_initiator_if.master   bus
);

  typedef struct packed {
    logic [1:0]  level;
    logic [3:0]  wrbe;
    logic        srcpriv;
    logic        nposted;
    logic        write;
    logic [31:0] wdat;
    logic [21:0] addr;
  } csb_req_t;

  typedef struct packed {
    logic        typ;
    logic        err;
    logic [31:0] dat;
  } csb_resp_t;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nxt;
  csb_req_t        req;
  csb_resp_t       resp;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     rdat_q;
  logic            err_q, to_q, perr_q;
  logic            accept, to_hit, type_ok;

  // cmd_ready is gated by reset so it reads 0 while reset is held
  assign bus.cmd_ready        = (state == IDLE) && !nvdla_core_rst;
  assign bus.csb2glb_req_pvld = (state == REQ);
  assign bus.csb2glb_req_pd   = req;
  assign bus.rsp_valid        = (state == DONE);
  assign bus.rsp_rdat         = rdat_q;
  assign bus.rsp_error        = err_q;
  assign bus.rsp_timeout      = to_q;
  assign bus.proto_err        = perr_q;

  assign resp    = bus.glb2csb_resp_pd;
  assign accept  = bus.cmd_valid && bus.cmd_ready;
  assign to_hit  = TO_EN && (to_cnt == TO_LAST);
  assign type_ok = (resp.typ == req.write);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (accept) state_nxt = REQ;
      REQ:      if (bus.csb2glb_req_prdy)
                  state_nxt = (req.write && !req.nposted) ? DONE : WAIT_RSP;
      WAIT_RSP: if (bus.glb2csb_resp_valid || to_hit) state_nxt = DONE;
      DONE:     if (bus.rsp_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state  <= IDLE;
      req    <= '0;
      to_cnt <= '0;
      rdat_q <= '0;
      err_q  <= 1'b0;
      to_q   <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req.level   <= 2'b00;
        req.wrbe    <= 4'hF;
        req.srcpriv <= 1'b0;
        req.nposted <= bus.cmd_write & bus.cmd_nposted;
        req.write   <= bus.cmd_write;
        req.wdat    <= bus.cmd_write ? bus.cmd_wdat : 32'h0;
        req.addr    <= bus.cmd_addr;
      end
      // a response is only legal while waiting; anywhere else it is flagged and dropped
      if (bus.glb2csb_resp_valid && state != WAIT_RSP) perr_q <= 1'b1;
      unique case (state)
        REQ: if (bus.csb2glb_req_prdy) begin
          to_cnt <= '0;
          rdat_q <= '0;
          err_q  <= 1'b0;
          to_q   <= 1'b0;
        end
        WAIT_RSP: begin
          if (bus.glb2csb_resp_valid) begin
            if (type_ok) begin
              rdat_q <= req.write ? 32'h0 : resp.dat;
              err_q  <= resp.err;
            end else begin
              perr_q <= 1'b1;
              rdat_q <= '0;
              err_q  <= 1'b1;
            end
          end else if (to_hit) begin
            to_q   <= 1'b1;
            err_q  <= 1'b1;
            rdat_q <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        DONE: if (bus.rsp_ready) begin
          rdat_q <= '0;
          err_q  <= 1'b0;
          to_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nvdla_csb_initiator.sv
// Directed bench for nvdla_csb_initiator: expected completions are queued at command time
// and popped when the host completion handshake happens.
module tb_nvdla_csb_initiator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [31:0] rdat;
    logic        err;
    logic        to;
  } exp_t;

  exp_t sb[$];

  nvdla_csb_initiator_if bus();

  nvdla_csb_initiator #(.TIMEOUT_CYCLES(8), .TO_W(16)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [62:0] mk_pd(input logic [21:0] a, input logic [31:0] d,
                                        input logic wr, input logic np);
    return {2'b00, 4'hF, 1'b0, wr & np, wr, (wr ? d : 32'h0), a};
  endfunction

  task automatic send_cmd(input logic [21:0] a, input logic [31:0] d, input logic wr,
                          input logic np, input exp_t e);
    for (int i = 0; i < 50 && !bus.cmd_ready; i++) tick();
    chk("cmd_ready_wait", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_wdat = d;
    bus.cmd_write = wr;   bus.cmd_nposted = np;
    tick();
    bus.cmd_valid = 1'b0;
    sb.push_back(e);
    chk("req_pvld", bus.csb2glb_req_pvld, 1'b1);
    chk("req_pd", bus.csb2glb_req_pd, mk_pd(a, d, wr, np));
  endtask

  // hold prdy low for 'stall' cycles, checking the request stays put, then handshake
  task automatic req_handshake(input int stall);
    logic [62:0] pd0;
    pd0 = bus.csb2glb_req_pd;
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("req_pvld_hold", bus.csb2glb_req_pvld, 1'b1);
      chk("req_pd_hold", bus.csb2glb_req_pd, pd0);
    end
    bus.csb2glb_req_prdy = 1'b1;
    tick();
    bus.csb2glb_req_prdy = 1'b0;
    chk("req_pvld_drop", bus.csb2glb_req_pvld, 1'b0);
  endtask

  task automatic send_resp(input logic typ, input logic err, input logic [31:0] dat);
    bus.glb2csb_resp_valid = 1'b1;
    bus.glb2csb_resp_pd    = {typ, err, dat};
    tick();
    bus.glb2csb_resp_valid = 1'b0;
    bus.glb2csb_resp_pd    = '0;
  endtask

  // wait for the completion, stall rsp_ready 'stall' cycles, then compare against the scoreboard
  task automatic expect_rsp(input int stall);
    exp_t e;
    logic [33:0] held;
    for (int i = 0; i < 50 && !bus.rsp_valid; i++) tick();
    chk("rsp_valid_wait", bus.rsp_valid, 1'b1);
    held = {bus.rsp_timeout, bus.rsp_error, bus.rsp_rdat};
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("rsp_valid_hold", bus.rsp_valid, 1'b1);
      chk("rsp_fields_hold", {bus.rsp_timeout, bus.rsp_error, bus.rsp_rdat}, held);
      chk("cmd_ready_blocked", bus.cmd_ready, 1'b0);
    end
    if (sb.size() == 0) begin
      chk("sb_nonempty", 1'b0, 1'b1);
    end else begin
      e = sb.pop_front();
      chk("rsp_rdat", bus.rsp_rdat, e.rdat);
      chk("rsp_error", bus.rsp_error, e.err);
      chk("rsp_timeout", bus.rsp_timeout, e.to);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", bus.rsp_valid, 1'b0);
    chk("cmd_ready_after", bus.cmd_ready, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, bus.cmd_ready, 1'b0);
    chk({tag, "_pvld"}, bus.csb2glb_req_pvld, 1'b0);
    chk({tag, "_pd"}, bus.csb2glb_req_pd, 63'h0);
    chk({tag, "_rsp"}, {bus.rsp_valid, bus.rsp_error, bus.rsp_timeout, bus.rsp_rdat}, 35'h0);
    chk({tag, "_proto_err"}, bus.proto_err, 1'b0);
  endtask

  initial begin
    exp_t e;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_wdat = '0;
    bus.cmd_write = 1'b0; bus.cmd_nposted = 1'b0;
    bus.csb2glb_req_prdy = 1'b0;
    bus.glb2csb_resp_valid = 1'b0; bus.glb2csb_resp_pd = '0;
    bus.rsp_ready = 1'b0;

    tick(); tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk("idle_cmd_ready", bus.cmd_ready, 1'b1);

    // read answered 3 cycles after the request handshake; wdat/nposted must be masked
    e = '{rdat: 32'hDEADBEEF, err: 1'b0, to: 1'b0};
    send_cmd(22'h000004, 32'h12345678, 1'b0, 1'b1, e);
    chk("read_pd_literal", bus.csb2glb_req_pd, 63'h1E00000000000004);
    req_handshake(0);
    tick();
    chk("read_wait_no_rsp", bus.rsp_valid, 1'b0);
    tick();
    send_resp(1'b0, 1'b0, 32'hDEADBEEF);
    chk("read_rsp_next_cycle", bus.rsp_valid, 1'b1);
    expect_rsp(0);
    chk("read_proto_err", bus.proto_err, 1'b0);

    // posted write with 5 cycles of request backpressure; completes without a response
    e = '{rdat: 32'h0, err: 1'b0, to: 1'b0};
    send_cmd(22'h000008, 32'h0000003F, 1'b1, 1'b0, e);
    req_handshake(5);
    chk("posted_rsp_valid", bus.rsp_valid, 1'b1);
    expect_rsp(0);

    // nonposted write: target error propagates, rdat forced to 0
    e = '{rdat: 32'h0, err: 1'b1, to: 1'b0};
    send_cmd(22'h000010, 32'h0000CAFE, 1'b1, 1'b1, e);
    req_handshake(1);
    chk("np_wait_no_rsp", bus.rsp_valid, 1'b0);
    send_resp(1'b1, 1'b1, 32'h000055AA);
    expect_rsp(0);
    chk("np_proto_err", bus.proto_err, 1'b0);

    // timeout: completion exactly 8 cycles after the request handshake, late response flagged
    e = '{rdat: 32'h0, err: 1'b1, to: 1'b1};
    send_cmd(22'h000020, 32'h0, 1'b0, 1'b0, e);
    req_handshake(0);
    for (int i = 1; i < 8; i++) tick();
    chk("to_not_yet", bus.rsp_valid, 1'b0);
    tick();
    chk("to_rsp_valid", bus.rsp_valid, 1'b1);
    chk("to_flag", bus.rsp_timeout, 1'b1);
    tick();
    send_resp(1'b0, 1'b0, 32'h11112222);
    chk("late_proto_err", bus.proto_err, 1'b1);
    expect_rsp(0);

    // clear the sticky flag before the mismatch case
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("proto_err_cleared", bus.proto_err, 1'b0);

    // read answered with a write-type response, completion held by rsp_ready for 4 cycles
    e = '{rdat: 32'h0, err: 1'b1, to: 1'b0};
    send_cmd(22'h000030, 32'h0, 1'b0, 1'b0, e);
    req_handshake(0);
    tick();
    send_resp(1'b1, 1'b0, 32'hA5A5A5A5);
    chk("mm_proto_err", bus.proto_err, 1'b1);
    expect_rsp(4);

    // reset during WAIT_RSP drops the transaction; a following response is flagged
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    e = '{rdat: 32'h0, err: 1'b0, to: 1'b0};
    send_cmd(22'h000040, 32'h0, 1'b0, 1'b0, e);
    req_handshake(0);
    tick();
    rst = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    sb.delete();
    rst = 1'b0;
    tick();
    chk("midrst_idle", bus.cmd_ready, 1'b1);
    send_resp(1'b0, 1'b0, 32'hBEEFBEEF);
    chk("midrst_late_proto_err", bus.proto_err, 1'b1);
    chk("midrst_no_rsp", bus.rsp_valid, 1'b0);
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
